// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue
// -----------------
// Circular instruction buffer between fetch and decode. Fetch pushes one
// instruction per cycle with its address, mode flag, PID and TID. Decode
// receives at most one instruction per cycle through a registered output
// stage. Each issued instruction is tagged with a monotonically increasing
// major ID that survives flushes, so an ID is never reused.
//
// Ports:
//   clock_i, reset_i          clock, asynchronous active-low reset
//   enable_i + *_i fields     push request and instruction fields from fetch
//   stall_i                   decode cannot accept; the output stage holds
//   flush_i                   discard all queued and presented instructions
//   enable_o + *_o fields     instruction presented to decode
//   instructionMajId_o        major ID of the presented instruction
//   full_o, empty_o, count_o  occupancy of the queue, excluding the output stage
module fetch_issue_queue #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int queueDepth              = 8,
    parameter int queueAddrWidth          = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic                               stall_i,
    input  logic                               flush_i,
    output logic                               enable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [queueAddrWidth:0]            count_o
);

    localparam logic [queueAddrWidth:0] FULL_COUNT = (queueAddrWidth+1)'(queueDepth);

    // Entry storage, one array per field
    logic [instructionWidth-1:0] mem_instr [queueDepth];
    logic [addressWidth-1:0]     mem_addr  [queueDepth];
    logic                        mem_is64  [queueDepth];
    logic [PidSize-1:0]          mem_pid   [queueDepth];
    logic [TidSize-1:0]          mem_tid   [queueDepth];

    logic [queueAddrWidth-1:0]          head;
    logic [queueAddrWidth-1:0]          tail;
    logic [queueAddrWidth:0]            count;
    logic [queueAddrWidth:0]            count_next;
    logic [instructionCounterWidth-1:0] maj_ctr;
    logic                               push;
    logic                               pop;

    assign full_o  = (count == FULL_COUNT);
    assign empty_o = (count == '0);
    assign count_o = count;

    // A push while full is dropped even if a pop frees a slot this cycle;
    // flush suppresses both push and pop.
    assign push = enable_i && !full_o && !flush_i;
    assign pop  = !stall_i && !empty_o && !flush_i;

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    // Entry storage carries no reset: contents are meaningless until written,
    // and pop only reads slots that count says are occupied.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_instr[tail] <= instruction_i;
            mem_addr[tail]  <= instructionAddress_i;
            mem_is64[tail]  <= is64Bit_i;
            mem_pid[tail]   <= instructionPid_i;
            mem_tid[tail]   <= instructionTid_i;
        end
    end

    // Pointers, occupancy, major-ID counter and the output stage. Flush wins
    // over everything except reset and deliberately leaves maj_ctr alone.
    // When decode is stalled the output stage holds completely.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            maj_ctr              <= '0;
            enable_o             <= 1'b0;
            instruction_o        <= '0;
            instructionAddress_o <= '0;
            is64Bit_o            <= 1'b0;
            instructionPid_o     <= '0;
            instructionTid_o     <= '0;
            instructionMajId_o   <= '0;
        end else if (flush_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            enable_o <= 1'b0;
        end else begin
            count <= count_next;
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head                 <= head + 1'b1;
                enable_o             <= 1'b1;
                instruction_o        <= mem_instr[head];
                instructionAddress_o <= mem_addr[head];
                is64Bit_o            <= mem_is64[head];
                instructionPid_o     <= mem_pid[head];
                instructionTid_o     <= mem_tid[head];
                instructionMajId_o   <= maj_ctr;
                maj_ctr              <= maj_ctr + 1'b1;
            end else if (!stall_i) begin
                enable_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_issue_queue.md
# fetch_issue_queue

Instruction buffer between fetch and `DecodeUnit`. It accepts fetched 32-bit instructions plus their address and context, and holds them in a circular FIFO. It issues at most one instruction per cycle to decode, using decode's `enable_i`/`stall_i` protocol, and assigns each issued instruction a monotonically increasing major ID.

## Interface
Parameters:
- `addressWidth`, 64: instruction address width.
- `instructionWidth`, 32: instruction width.
- `PidSize`, 20: process ID width.
- `TidSize`, 16: thread ID width.
- `instructionCounterWidth`, 64: major ID width.
- `queueDepth`, 8: entry count; must be a power of two, ≥2.
- `queueAddrWidth`, 3: log2(`queueDepth`).

Ports:
- `clock_i` in 1: the single clock; all state updates on its rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `enable_i` in 1: push request from fetch.
- `instruction_i` in `instructionWidth`: instruction word to push.
- `instructionAddress_i` in `addressWidth`: address of the pushed instruction.
- `is64Bit_i` in 1: 64-bit mode flag of the pushed instruction.
- `instructionPid_i` in `PidSize`: PID of the pushed instruction.
- `instructionTid_i` in `TidSize`: TID of the pushed instruction.
- `stall_i` in 1: decode cannot accept; the output stage holds.
- `flush_i` in 1: discard all queued and presented instructions.
- `enable_o` out 1: output stage holds a valid instruction for decode.
- `instruction_o`, `instructionAddress_o`, `is64Bit_o`, `instructionPid_o`, `instructionTid_o` out (matching widths): presented instruction fields.
- `instructionMajId_o` out `instructionCounterWidth`: major ID of the presented instruction.
- `full_o` out 1: `count == queueDepth`; fetch must not push.
- `empty_o` out 1: `count == 0`.
- `count_o` out `queueAddrWidth+1`: number of occupied entries, excluding the output stage.

## Operation
- Storage: `queueDepth` entries, each holding {instruction, address, is64Bit, pid, tid}.
  - Head and tail pointers are `queueAddrWidth` bits wide and wrap modulo `queueDepth`.
  - The separate `count` register disambiguates full from empty.
- Push: accepted when `enable_i && !full_o && !flush_i`.
  - The entry is written at the tail, and the tail advances.
  - A push while `full_o` is high is dropped silently, even if a pop happens in the same cycle. There is no bypass.
- Pop: occurs when `!stall_i && !empty_o && !flush_i`.
  - The head entry is loaded into the output registers and the head advances.
  - `enable_o` goes high.
  - `instructionMajId_o` takes the value of `majCtr`, and `majCtr` increments.
- No pop with `!stall_i` (queue empty): `enable_o` goes low. The data outputs hold their last values.
- `stall_i` high: every output register holds, including `enable_o` and the major ID. No pop occurs; pushes are still accepted.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Flush (highest priority):
  - Head, tail and `count` go to 0, and `enable_o` goes to 0.
  - A push in the same cycle is dropped.
  - `majCtr` is not reset, so IDs are never reused.
  - The flush overrides `stall_i`.
- `majCtr`: `instructionCounterWidth` bits, starts at 0 after reset, wraps from all-ones to 0.
- Reset (asynchronous, `reset_i` low), effective immediately, including mid-operation:
  - Pointers, `count` and `majCtr` go to 0.
  - `enable_o` goes to 0 and all data outputs go to 0.
  - `empty_o` goes to 1 and `full_o` goes to 0.
  - Queue contents are don't-care.

## Timing
- Minimum latency is 1 cycle. A push at edge N into an empty queue gives `enable_o` high after edge N+1, with `count_o` 1 after N and 0 after N+1.
- Throughput is 1 instruction per cycle when fetch pushes every cycle and decode does not stall.
- `full_o`, `empty_o` and `count_o` are registered, derived from the post-edge `count`. Fetch samples `full_o` in the same cycle it drives `enable_i`.
- An instruction presented while `stall_i` is high remains presented unchanged until the first edge with `stall_i` low. At that edge it is replaced by the next head entry, or `enable_o` drops.

## Test plan
- Reset, then push 0x7C221A14 @ addr 0x1000 (pid 5, tid 3):
  - After edge 1: `count_o`=1, `enable_o`=0.
  - After edge 2: `enable_o`=1, `instruction_o`=0x7C221A14, `instructionAddress_o`=0x1000, `instructionMajId_o`=0, `empty_o`=1.
- With `stall_i`=1, push 10 instructions at addrs 0x0,0x4,…:
  - The first 8 are accepted, `full_o`=1, `count_o`=8, and pushes 9–10 are dropped.
  - Release the stall: 8 consecutive issues, addrs 0x0–0x1C, majIDs 0–7, no gaps.
- Continuous push and pop for 20 cycles with no stall: `count_o` stays at 1. The pointers wrap twice, and the 20 outputs appear in order with majIDs incrementing by 1.
- Stall asserted while `enable_o`=1 with majID 3, held for 4 cycles: all outputs are constant. On release, the next instruction appears with majID 4.
- `flush_i` with 5 entries queued and `enable_o`=1, while pushing in the same cycle:
  - Next cycle: `enable_o`=0, `count_o`=0, `empty_o`=1.
  - A subsequent push issues with majID continuing from the pre-flush value (no reuse).
- Drive `reset_i` low between clock edges with 3 entries queued: all outputs reach their reset values before the next edge. After reset release, the first issued majID is 0.
